// File: rtl/mips_mc_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// mips_mc_pkg
// Shared definitions for the multicycle MIPS controller: state encoding,
// opcode/funct constants (same values as mips_op_codes_defines and
// mips_funct_defines), datapath select encodings and the packed control
// word driven by the FSM.
// ---------------------------------------------------------------------------
package mips_mc_pkg;

  // State encoding, 4 bits.
  localparam logic [3:0] ST_FETCH    = 4'd0;
  localparam logic [3:0] ST_DECODE   = 4'd1;
  localparam logic [3:0] ST_EXEC_R   = 4'd2;
  localparam logic [3:0] ST_EXEC_I   = 4'd3;
  localparam logic [3:0] ST_MEM_ADDR = 4'd4;
  localparam logic [3:0] ST_MEM_RD   = 4'd5;
  localparam logic [3:0] ST_MEM_RWB  = 4'd6;
  localparam logic [3:0] ST_MEM_WR   = 4'd7;
  localparam logic [3:0] ST_BRANCH   = 4'd8;
  localparam logic [3:0] ST_JUMP     = 4'd9;
  localparam logic [3:0] ST_JR       = 4'd10;
  localparam logic [3:0] ST_WB_R     = 4'd11;
  localparam logic [3:0] ST_WB_I     = 4'd12;
  localparam logic [3:0] ST_ERROR    = 4'd13;

  typedef enum logic [3:0] {
    S_FETCH    = ST_FETCH,
    S_DECODE   = ST_DECODE,
    S_EXEC_R   = ST_EXEC_R,
    S_EXEC_I   = ST_EXEC_I,
    S_MEM_ADDR = ST_MEM_ADDR,
    S_MEM_RD   = ST_MEM_RD,
    S_MEM_RWB  = ST_MEM_RWB,
    S_MEM_WR   = ST_MEM_WR,
    S_BRANCH   = ST_BRANCH,
    S_JUMP     = ST_JUMP,
    S_JR       = ST_JR,
    S_WB_R     = ST_WB_R,
    S_WB_I     = ST_WB_I,
    S_ERROR    = ST_ERROR
  } state_e;

  // Opcodes.
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type funct values the controller cares about.
  localparam logic [5:0] FN_SLL = 6'h00;
  localparam logic [5:0] FN_SRL = 6'h02;
  localparam logic [5:0] FN_SRA = 6'h03;
  localparam logic [5:0] FN_JR  = 6'h08;

  // Datapath select encodings.
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_IMM   = 2'b11;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_A     = 2'b01;
  localparam logic [1:0] SRCA_SHAMT = 2'b10;

  localparam logic [2:0] SRCB_B      = 3'b000;
  localparam logic [2:0] SRCB_FOUR   = 3'b001;
  localparam logic [2:0] SRCB_IMM    = 3'b010;
  localparam logic [2:0] SRCB_IMMSH2 = 3'b011;
  localparam logic [2:0] SRCB_BSHIFT = 3'b100;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;
  localparam logic [1:0] PCSRC_REGA   = 2'b11;

  localparam logic [1:0] REGDST_RT = 2'b00;
  localparam logic [1:0] REGDST_RD = 2'b01;
  localparam logic [1:0] REGDST_RA = 2'b10;

  localparam logic [1:0] M2R_ALUOUT = 2'b00;
  localparam logic [1:0] M2R_MDR    = 2'b01;
  localparam logic [1:0] M2R_PC     = 2'b10;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_ILLEGAL = 2'b01;
  localparam logic [1:0] ERR_TMO     = 2'b10;

  // Full control word; all-zero is the idle / reset value.
  typedef struct packed {
    logic       mem_req;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic       pc_write;
    logic       pc_write_cond;
    logic       branch_ne;
    logic       i_or_d;
    logic [1:0] alu_src_a;
    logic [2:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic       error;
    logic [1:0] err_code;
  } ctrl_t;

endpackage

// File: rtl/mips_mc_ctrl_if.sv
// ---------------------------------------------------------------------------
// mips_mc_ctrl_if
// Bundle between the instruction register / memory and the multicycle
// controller, plus the controller's datapath select and enable outputs.
//   master : controller side (reads IR fields and mem_ready, drives controls)
//   slave  : datapath / memory side
// ---------------------------------------------------------------------------
interface mips_mc_ctrl_if #(
  parameter int OP_W    = 6,
  parameter int FUNCT_W = 6
);
  logic [OP_W-1:0]    Op_code;
  logic [FUNCT_W-1:0] Funct;
  logic               mem_ready;
  logic               mem_req;
  logic               MemWrite;
  logic               IRWrite;
  logic               RegWrite;
  logic               PCWrite;
  logic               PCWriteCond;
  logic               BranchNe;
  logic               IorD;
  logic [1:0]         ALUSrcA;
  logic [2:0]         ALUSrcB;
  logic [1:0]         ALUOp;
  logic [1:0]         PCSource;
  logic [1:0]         RegDst;
  logic [1:0]         MemtoReg;
  logic               error;
  logic [1:0]         err_code;

  modport master (
    input  Op_code, Funct, mem_ready,
    output mem_req, MemWrite, IRWrite, RegWrite, PCWrite, PCWriteCond,
           BranchNe, IorD, ALUSrcA, ALUSrcB, ALUOp, PCSource, RegDst,
           MemtoReg, error, err_code
  );

  modport slave (
    output Op_code, Funct, mem_ready,
    input  mem_req, MemWrite, IRWrite, RegWrite, PCWrite, PCWriteCond,
           BranchNe, IorD, ALUSrcA, ALUSrcB, ALUOp, PCSource, RegDst,
           MemtoReg, error, err_code
  );
endinterface

// File: rtl/mips_mc_ctrl_wait_timer.sv
// ---------------------------------------------------------------------------
// mips_mc_wait_timer
// Saturating memory-stall counter with timeout compare. Only built when
// MIPS_MC_CTRL_MEMWAIT_EN is defined.
// Ports:
//   clk, rst   : clock, asynchronous active-low reset
//   clear_i    : restart the count (state change in the controller)
//   stall_i    : a memory state is waiting on mem_ready this cycle
//   timeout_o  : count has reached MEM_TIMEOUT-1 (0 when MEM_TIMEOUT == 0)
// ---------------------------------------------------------------------------
`ifdef MIPS_MC_CTRL_MEMWAIT_EN
module mips_mc_wait_timer #(
  parameter int TMO_W       = 8,
  parameter int MEM_TIMEOUT = 200
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic stall_i,
  output logic timeout_o
);

  logic [TMO_W-1:0] cnt_q, cnt_d;

  // NOTE: cnt_d gets its hold value first so every path assigns it and no
  // latch is inferred.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i)
      cnt_d = '0;
    else if (stall_i && (cnt_q != '1))   // saturate, never wrap
      cnt_d = cnt_q + 1'b1;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  generate
    if (MEM_TIMEOUT == 0) begin : g_no_tmo
      assign timeout_o = 1'b0;
    end else begin : g_tmo
      assign timeout_o = (cnt_q == TMO_W'(MEM_TIMEOUT - 1));
    end
  endgenerate

endmodule
`endif

// File: rtl/mips_mc_ctrl.sv
// ---------------------------------------------------------------------------
// mips_mc_ctrl
// Multicycle MIPS control FSM (Moore; outputs decode from state, plus Funct
// for shifts/JR). Supports R-type, I-ALU, LW/SW, BEQ/BNE, J/JAL/JR, with a
// sticky ERROR state for illegal opcodes and memory timeouts.
// Configuration macro: MIPS_MC_CTRL_MEMWAIT_EN
//   defined   : mem_ready handshake and stall timeout are active
//   undefined : mem_ready ignored (treated as 1), no timeout logic
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-low reset; also forces all outputs to 0
//   bus  : mips_mc_ctrl_if.master (Op_code, Funct, mem_ready in;
//          mem_req, enables, mux selects, error, err_code out)
// ---------------------------------------------------------------------------
module mips_mc_ctrl
  import mips_mc_pkg::*;
#(
  parameter int OP_W        = 6,
  parameter int FUNCT_W     = 6,
  parameter int TMO_W       = 8,
  parameter int MEM_TIMEOUT = 200
) (
  input  logic           clk,
  input  logic           rst,
  mips_mc_ctrl_if.master bus
);

  state_e     state_q, state_d;
  logic [1:0] err_q, err_d;
  ctrl_t      ctrl_c, ctrl_o;
  logic       mem_ok;     // the current memory access completes this cycle
  logic       tmo;        // stall limit reached

`ifdef MIPS_MC_CTRL_MEMWAIT_EN
  logic in_mem;
  assign in_mem = (state_q == S_FETCH) || (state_q == S_MEM_RD) ||
                  (state_q == S_MEM_WR);
  assign mem_ok = bus.mem_ready;

  // Any state change restarts the count, which covers entry to each memory
  // state; a ready in the timeout cycle still wins because mem_ok is tested
  // before tmo below.
  mips_mc_wait_timer #(
    .TMO_W      (TMO_W),
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_wait_timer (
    .clk      (clk),
    .rst      (rst),
    .clear_i  (state_d != state_q),
    .stall_i  (in_mem && !bus.mem_ready),
    .timeout_o(tmo)
  );
`else
  assign mem_ok = 1'b1;
  assign tmo    = 1'b0;
  logic unused_cfg;
  assign unused_cfg = ^{bus.mem_ready, (TMO_W > 0), (MEM_TIMEOUT > 0)};
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_FETCH;
      err_q   <= ERR_NONE;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    ctrl_c  = '0;
    case (state_q)
      S_FETCH: begin
        ctrl_c.mem_req   = 1'b1;
        ctrl_c.alu_src_a = SRCA_PC;
        ctrl_c.alu_src_b = SRCB_FOUR;
        ctrl_c.alu_op    = ALUOP_ADD;
        ctrl_c.pc_source = PCSRC_ALU;
        if (mem_ok) begin
          ctrl_c.ir_write = 1'b1;
          ctrl_c.pc_write = 1'b1;
          state_d         = S_DECODE;
        end else if (tmo) begin
          state_d = S_ERROR;
          err_d   = ERR_TMO;
        end
      end
      S_DECODE: begin
        ctrl_c.alu_src_a = SRCA_PC;
        ctrl_c.alu_src_b = SRCB_IMMSH2;   // precompute branch target
        ctrl_c.alu_op    = ALUOP_ADD;
        case (bus.Op_code)
          OP_W'(OP_RTYPE):
            state_d = (bus.Funct == FUNCT_W'(FN_JR)) ? S_JR : S_EXEC_R;
          OP_W'(OP_J), OP_W'(OP_JAL):
            state_d = S_JUMP;
          OP_W'(OP_BEQ), OP_W'(OP_BNE):
            state_d = S_BRANCH;
          OP_W'(OP_ADDI), OP_W'(OP_SLTI), OP_W'(OP_ANDI), OP_W'(OP_ORI),
          OP_W'(OP_XORI):
            state_d = S_EXEC_I;
          OP_W'(OP_LW), OP_W'(OP_SW):
            state_d = S_MEM_ADDR;
          default: begin
            state_d = S_ERROR;
            err_d   = ERR_ILLEGAL;
          end
        endcase
      end
      S_EXEC_R: begin
        if ((bus.Funct == FUNCT_W'(FN_SLL)) || (bus.Funct == FUNCT_W'(FN_SRL)) ||
            (bus.Funct == FUNCT_W'(FN_SRA))) begin
          ctrl_c.alu_src_a = SRCA_SHAMT;
          ctrl_c.alu_src_b = SRCB_BSHIFT;
        end else begin
          ctrl_c.alu_src_a = SRCA_A;
          ctrl_c.alu_src_b = SRCB_B;
        end
        ctrl_c.alu_op = ALUOP_FUNCT;
        state_d       = S_WB_R;
      end
      S_WB_R: begin
        ctrl_c.reg_dst    = REGDST_RD;
        ctrl_c.mem_to_reg = M2R_ALUOUT;
        ctrl_c.reg_write  = 1'b1;
        state_d           = S_FETCH;
      end
      S_EXEC_I: begin
        ctrl_c.alu_src_a = SRCA_A;
        ctrl_c.alu_src_b = SRCB_IMM;
        ctrl_c.alu_op    = ALUOP_IMM;
        state_d          = S_WB_I;
      end
      S_WB_I: begin
        ctrl_c.reg_dst    = REGDST_RT;
        ctrl_c.mem_to_reg = M2R_ALUOUT;
        ctrl_c.reg_write  = 1'b1;
        state_d           = S_FETCH;
      end
      S_MEM_ADDR: begin
        ctrl_c.alu_src_a = SRCA_A;
        ctrl_c.alu_src_b = SRCB_IMM;
        ctrl_c.alu_op    = ALUOP_ADD;
        state_d = (bus.Op_code == OP_W'(OP_LW)) ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        ctrl_c.mem_req = 1'b1;
        ctrl_c.i_or_d  = 1'b1;
        if (mem_ok) begin
          state_d = S_MEM_RWB;
        end else if (tmo) begin
          state_d = S_ERROR;
          err_d   = ERR_TMO;
        end
      end
      S_MEM_RWB: begin
        ctrl_c.reg_dst    = REGDST_RT;
        ctrl_c.mem_to_reg = M2R_MDR;
        ctrl_c.reg_write  = 1'b1;
        state_d           = S_FETCH;
      end
      S_MEM_WR: begin
        ctrl_c.mem_req   = 1'b1;
        ctrl_c.i_or_d    = 1'b1;
        ctrl_c.mem_write = 1'b1;
        if (mem_ok) begin
          state_d = S_FETCH;
        end else if (tmo) begin
          state_d = S_ERROR;
          err_d   = ERR_TMO;
        end
      end
      S_BRANCH: begin
        ctrl_c.alu_src_a     = SRCA_A;
        ctrl_c.alu_src_b     = SRCB_B;
        ctrl_c.alu_op        = ALUOP_SUB;
        ctrl_c.pc_source     = PCSRC_ALUOUT;
        ctrl_c.pc_write_cond = 1'b1;
        ctrl_c.branch_ne     = (bus.Op_code == OP_W'(OP_BNE));
        state_d              = S_FETCH;
      end
      S_JUMP: begin
        ctrl_c.pc_source = PCSRC_JUMP;
        ctrl_c.pc_write  = 1'b1;
        if (bus.Op_code == OP_W'(OP_JAL)) begin
          ctrl_c.reg_dst    = REGDST_RA;
          ctrl_c.mem_to_reg = M2R_PC;
          ctrl_c.reg_write  = 1'b1;
        end
        state_d = S_FETCH;
      end
      S_JR: begin
        ctrl_c.pc_source = PCSRC_REGA;
        ctrl_c.pc_write  = 1'b1;
        state_d          = S_FETCH;
      end
      S_ERROR: begin
        ctrl_c.error    = 1'b1;
        ctrl_c.err_code = err_q;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // Outputs are gated directly by rst so FETCH cannot pulse PCWrite/IRWrite
  // while reset is still asserted.
  assign ctrl_o = rst ? ctrl_c : '0;

  assign bus.mem_req     = ctrl_o.mem_req;
  assign bus.MemWrite    = ctrl_o.mem_write;
  assign bus.IRWrite     = ctrl_o.ir_write;
  assign bus.RegWrite    = ctrl_o.reg_write;
  assign bus.PCWrite     = ctrl_o.pc_write;
  assign bus.PCWriteCond = ctrl_o.pc_write_cond;
  assign bus.BranchNe    = ctrl_o.branch_ne;
  assign bus.IorD        = ctrl_o.i_or_d;
  assign bus.ALUSrcA     = ctrl_o.alu_src_a;
  assign bus.ALUSrcB     = ctrl_o.alu_src_b;
  assign bus.ALUOp       = ctrl_o.alu_op;
  assign bus.PCSource    = ctrl_o.pc_source;
  assign bus.RegDst      = ctrl_o.reg_dst;
  assign bus.MemtoReg    = ctrl_o.mem_to_reg;
  assign bus.error       = ctrl_o.error;
  assign bus.err_code    = ctrl_o.err_code;

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mips_mc_ctrl
// Directed bench for mips_mc_ctrl. Inputs change and outputs are sampled on
// the falling clock edge. Expected control words are written out by hand
// from the state table. Stall/timeout cases run when MIPS_MC_CTRL_MEMWAIT_EN
// is defined; otherwise the bench checks that mem_ready is ignored.
// ---------------------------------------------------------------------------
module tb_mips_mc_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mips_mc_ctrl_if #(.OP_W(6), .FUNCT_W(6)) bus ();

  mips_mc_ctrl #(
    .OP_W       (6),
    .FUNCT_W    (6),
    .TMO_W      (8),
    .MEM_TIMEOUT(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Control word layout: {mem_req, MemWrite, IRWrite, RegWrite, PCWrite,
  // PCWriteCond, BranchNe, IorD, ALUSrcA, ALUSrcB, ALUOp, PCSource, RegDst,
  // MemtoReg, error, err_code}
  function automatic logic [31:0] obs();
    return {8'h00, bus.mem_req, bus.MemWrite, bus.IRWrite, bus.RegWrite,
            bus.PCWrite, bus.PCWriteCond, bus.BranchNe, bus.IorD,
            bus.ALUSrcA, bus.ALUSrcB, bus.ALUOp, bus.PCSource, bus.RegDst,
            bus.MemtoReg, bus.error, bus.err_code};
  endfunction

  function automatic logic [31:0] cv(input logic [7:0] en, input logic [1:0] sa,
                                     input logic [2:0] sb, input logic [1:0] aop,
                                     input logic [1:0] pcs, input logic [1:0] rd,
                                     input logic [1:0] m2r, input logic err,
                                     input logic [1:0] ec);
    return {8'h00, en, sa, sb, aop, pcs, rd, m2r, err, ec};
  endfunction

  logic [31:0] E_ZERO, E_FETCH_GO, E_FETCH_WAIT, E_DECODE, E_EXEC_R, E_EXEC_SH,
               E_WB_R, E_EXEC_I, E_WB_I, E_MEM_ADDR, E_MEM_RD, E_MEM_RWB,
               E_MEM_WR, E_BR_EQ, E_BR_NE, E_J, E_JAL, E_JR, E_ERR_ILL,
               E_ERR_TMO;

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic fetch_go(input string tag);
    check(tag, obs(), E_FETCH_GO);
    step();
  endtask

  task automatic set_instr(input logic [5:0] op, input logic [5:0] fn);
    bus.Op_code = op;
    bus.Funct   = fn;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    //                 en            sa     sb      aop    pcs    rd     m2r   err ec
    E_ZERO       = cv(8'b0000_0000, 2'b00, 3'b000, 2'b00, 2'b00, 2'b00, 2'b00, 0, 2'b00);
    E_FETCH_GO   = cv(8'b1010_1000, 2'b00, 3'b001, 2'b00, 2'b00, 2'b00, 2'b00, 0, 2'b00);
    E_FETCH_WAIT = cv(8'b1000_0000, 2'b00, 3'b001, 2'b00, 2'b00, 2'b00, 2'b00, 0, 2'b00);
    E_DECODE     = cv(8'b0000_0000, 2'b00, 3'b011, 2'b00, 2'b00, 2'b00, 2'b00, 0, 2'b00);
    E_EXEC_R     = cv(8'b0000_0000, 2'b01, 3'b000, 2'b10, 2'b00, 2'b00, 2'b00, 0, 2'b00);
    E_EXEC_SH    = cv(8'b0000_0000, 2'b10, 3'b100, 2'b10, 2'b00, 2'b00, 2'b00, 0, 2'b00);
    E_WB_R       = cv(8'b0001_0000, 2'b00, 3'b000, 2'b00, 2'b00, 2'b01, 2'b00, 0, 2'b00);
    E_EXEC_I     = cv(8'b0000_0000, 2'b01, 3'b010, 2'b11, 2'b00, 2'b00, 2'b00, 0, 2'b00);
    E_WB_I       = cv(8'b0001_0000, 2'b00, 3'b000, 2'b00, 2'b00, 2'b00, 2'b00, 0, 2'b00);
    E_MEM_ADDR   = cv(8'b0000_0000, 2'b01, 3'b010, 2'b00, 2'b00, 2'b00, 2'b00, 0, 2'b00);
    E_MEM_RD     = cv(8'b1000_0001, 2'b00, 3'b000, 2'b00, 2'b00, 2'b00, 2'b00, 0, 2'b00);
    E_MEM_RWB    = cv(8'b0001_0000, 2'b00, 3'b000, 2'b00, 2'b00, 2'b00, 2'b01, 0, 2'b00);
    E_MEM_WR     = cv(8'b1100_0001, 2'b00, 3'b000, 2'b00, 2'b00, 2'b00, 2'b00, 0, 2'b00);
    E_BR_EQ      = cv(8'b0000_0100, 2'b01, 3'b000, 2'b01, 2'b01, 2'b00, 2'b00, 0, 2'b00);
    E_BR_NE      = cv(8'b0000_0110, 2'b01, 3'b000, 2'b01, 2'b01, 2'b00, 2'b00, 0, 2'b00);
    E_J          = cv(8'b0000_1000, 2'b00, 3'b000, 2'b00, 2'b10, 2'b00, 2'b00, 0, 2'b00);
    E_JAL        = cv(8'b0001_1000, 2'b00, 3'b000, 2'b00, 2'b10, 2'b10, 2'b10, 0, 2'b00);
    E_JR         = cv(8'b0000_1000, 2'b00, 3'b000, 2'b00, 2'b11, 2'b00, 2'b00, 0, 2'b00);
    E_ERR_ILL    = cv(8'b0000_0000, 2'b00, 3'b000, 2'b00, 2'b00, 2'b00, 2'b00, 1, 2'b01);
    E_ERR_TMO    = cv(8'b0000_0000, 2'b00, 3'b000, 2'b00, 2'b00, 2'b00, 2'b00, 1, 2'b10);

    // Reset held for 3 cycles: every output must be 0.
    rst           = 1'b0;
    bus.mem_ready = 1'b1;
    set_instr(6'h00, 6'h20);          // ADD
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("reset_zero", obs(), E_ZERO);
    end
    rst = 1'b1;
    #1;

    // ADD: FETCH, DECODE, EXEC_R, WB_R.
    fetch_go("add_fetch_first");
    check("add_decode", obs(), E_DECODE);  step();
    check("add_exec_r", obs(), E_EXEC_R);  step();
    check("add_wb_r",   obs(), E_WB_R);    step();

    // SRL uses the shamt / B-shift selects.
    set_instr(6'h00, 6'h02);
    fetch_go("srl_fetch");
    check("srl_decode", obs(), E_DECODE);  step();
    check("srl_exec_r", obs(), E_EXEC_SH); step();
    check("srl_wb_r",   obs(), E_WB_R);    step();

    // ADDI.
    set_instr(6'h08, 6'h00);
    fetch_go("addi_fetch");
    check("addi_decode", obs(), E_DECODE); step();
    check("addi_exec_i", obs(), E_EXEC_I); step();
    check("addi_wb_i",   obs(), E_WB_I);   step();

    // LW with mem_ready low for 3 cycles in MEM_RD (ignored without the
    // handshake, where MEM_RD lasts a single cycle).
    set_instr(6'h23, 6'h00);
    fetch_go("lw_fetch");
    check("lw_decode",   obs(), E_DECODE);   step();
    check("lw_mem_addr", obs(), E_MEM_ADDR);
    bus.mem_ready = 1'b0;
    step();
`ifdef MIPS_MC_CTRL_MEMWAIT_EN
    for (int i = 0; i < 4; i++) begin
      if (i == 3) bus.mem_ready = 1'b1;
      check("lw_mem_rd", obs(), E_MEM_RD);
      step();
    end
`else
    check("lw_mem_rd", obs(), E_MEM_RD);
    step();
`endif
    bus.mem_ready = 1'b1;
    check("lw_mem_rwb", obs(), E_MEM_RWB);   step();

    // SW.
    set_instr(6'h2B, 6'h00);
    fetch_go("sw_fetch");
    check("sw_decode",   obs(), E_DECODE);   step();
    check("sw_mem_addr", obs(), E_MEM_ADDR); step();
    check("sw_mem_wr",   obs(), E_MEM_WR);   step();

    // BEQ / BNE.
    set_instr(6'h04, 6'h00);
    fetch_go("beq_fetch");
    check("beq_decode", obs(), E_DECODE); step();
    check("beq_branch", obs(), E_BR_EQ);  step();
    set_instr(6'h05, 6'h00);
    fetch_go("bne_fetch");
    check("bne_decode", obs(), E_DECODE); step();
    check("bne_branch", obs(), E_BR_NE);  step();

    // J / JAL / JR.
    set_instr(6'h02, 6'h00);
    fetch_go("j_fetch");
    check("j_decode", obs(), E_DECODE); step();
    check("j_jump",   obs(), E_J);      step();
    set_instr(6'h03, 6'h00);
    fetch_go("jal_fetch");
    check("jal_decode", obs(), E_DECODE); step();
    check("jal_jump",   obs(), E_JAL);    step();
    set_instr(6'h00, 6'h08);
    fetch_go("jr_fetch");
    check("jr_decode", obs(), E_DECODE); step();
    check("jr_jr",     obs(), E_JR);     step();

    // Illegal opcode: sticky ERROR for 10 cycles, then a reset pulse.
    set_instr(6'h3F, 6'h00);
    fetch_go("ill_fetch");
    check("ill_decode", obs(), E_DECODE); step();
    for (int i = 0; i < 10; i++) begin
      check("ill_error", obs(), E_ERR_ILL);
      step();
    end
    rst = 1'b0;
    #1;
    check("ill_reset_zero", obs(), E_ZERO);
    step();
    set_instr(6'h00, 6'h20);
    rst = 1'b1;
    #1;
    fetch_go("ill_recover_fetch");
    check("ill_recover_decode", obs(), E_DECODE); step();
    check("ill_recover_exec",   obs(), E_EXEC_R); step();
    check("ill_recover_wb",     obs(), E_WB_R);   step();

`ifdef MIPS_MC_CTRL_MEMWAIT_EN
    // Ready on the 4th stall cycle: the fetch completes.
    bus.mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("tmo_edge_wait", obs(), E_FETCH_WAIT);
      step();
    end
    bus.mem_ready = 1'b1;
    #1;
    fetch_go("tmo_edge_go");
    check("tmo_edge_decode", obs(), E_DECODE); step();
    check("tmo_edge_exec",   obs(), E_EXEC_R); step();
    check("tmo_edge_wb",     obs(), E_WB_R);   step();

    // No ready at all: ERROR after 4 stall cycles with err_code=10.
    bus.mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("tmo_wait", obs(), E_FETCH_WAIT);
      step();
    end
    check("tmo_error", obs(), E_ERR_TMO);
    bus.mem_ready = 1'b1;
    step();
    check("tmo_error_sticky", obs(), E_ERR_TMO);
    rst = 1'b0;
    #1;
    check("tmo_reset_zero", obs(), E_ZERO);
    step();
    rst = 1'b1;
    #1;
    fetch_go("tmo_recover_fetch");
    check("tmo_recover_decode", obs(), E_DECODE);
`else
    // Without the handshake, mem_ready=0 still lets the fetch complete.
    bus.mem_ready = 1'b0;
    #1;
    fetch_go("nowait_fetch");
    check("nowait_decode", obs(), E_DECODE); step();
    check("nowait_exec",   obs(), E_EXEC_R);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
